// File: rtl/dsp_pkg.sv
// Shared helpers for the DSP datapath: accumulator sizing, saturation and
// coefficient extraction from a packed coefficient vector.
package dsp_pkg;

  localparam int COEF_VEC_MAX = 4096;

  function automatic int acc_width(input int data_w, input int coef_w, input int order);
    return data_w + coef_w + $clog2(order);
  endfunction

  function automatic logic signed [63:0] sat_to(input logic signed [63:0] x, input int n);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (n - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (n - 1));
    if (x > hi) return hi;
    if (x < lo) return lo;
    return x;
  endfunction

  // Slice k counts from the most-significant end; result is sign-extended.
  function automatic logic signed [31:0] coef_at(input logic [COEF_VEC_MAX-1:0] coef,
                                                 input int order, input int coef_w,
                                                 input int k);
    logic signed [31:0] r;
    int base;
    base = (order - 1 - k) * coef_w;
    r = '0;
    for (int b = 0; b < 32; b++) begin
      if (b < coef_w) r[b] = coef[base + b];
      else            r[b] = coef[base + coef_w - 1];
    end
    return r;
  endfunction

endpackage

// File: rtl/fir_mod_delay_delay_line.sv
// Circular delay line with run-time tap offset; returns zero until the
// requested offset has actually been written since reset.
module delay_line
  import dsp_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int JMP_WIDTH  = 9
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic        [JMP_WIDTH-1:0]  jmp,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  input  logic                         vld_i,
  output logic signed [DATA_WIDTH-1:0] d_o,
  output logic                         d_vld_o
);

  localparam int DEPTH = 1 << JMP_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [JMP_WIDTH-1:0]  wptr_d, wptr_q;
  logic [JMP_WIDTH-1:0]  fill_d, fill_q;
  logic [JMP_WIDTH-1:0]  raddr;
  logic                  we;

  always_comb begin
    we      = vld_i && !rst;
    wptr_d  = wptr_q;
    fill_d  = fill_q;
    raddr   = wptr_q - jmp;
    d_vld_o = we;
    if (we) begin
      wptr_d = wptr_q + JMP_WIDTH'(1);
      if (fill_q != '1) fill_d = fill_q + JMP_WIDTH'(1);
    end
    // Read happens before the same-cycle write lands.
    if (jmp == '0)          d_o = data_i;
    else if (jmp > fill_q)  d_o = '0;
    else                    d_o = mem[raddr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q <= '0;
      fill_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      fill_q <= fill_d;
    end
  end

  always_ff @(posedge clk) begin
    if (we) mem[wptr_q] <= data_i;
  end

endmodule

// File: rtl/fir_mod_delay.sv
// Modulated-delay FIR: delayed sample stream through a fixed direct-form FIR,
// rounded toward minus infinity and saturated back to the sample width.
module fir_mod_delay
  import dsp_pkg::*;
#(
  parameter int ORDER      = 61,
  parameter int DATA_WIDTH = 8,
  parameter int COEF_WIDTH = 8,
  parameter int JMP_WIDTH  = 9,
  parameter logic [ORDER*COEF_WIDTH-1:0] COEF = {ORDER{COEF_WIDTH'(2)}}
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic        [JMP_WIDTH-1:0]  jmp,
  input  logic signed [DATA_WIDTH-1:0] data_i,
  input  logic                         vld_i,
  output logic signed [DATA_WIDTH-1:0] data_o,
  output logic                         vld_o
);

  localparam int ACC_W = acc_width(DATA_WIDTH, COEF_WIDTH, ORDER);

  logic signed [DATA_WIDTH-1:0] d;
  logic                         d_vld;

  delay_line #(
    .DATA_WIDTH (DATA_WIDTH),
    .JMP_WIDTH  (JMP_WIDTH)
  ) u_delay_line (
    .clk     (clk),
    .rst     (rst),
    .jmp     (jmp),
    .data_i  (data_i),
    .vld_i   (vld_i),
    .d_o     (d),
    .d_vld_o (d_vld)
  );

  logic signed [COEF_WIDTH-1:0] h [ORDER];

  for (genvar g = 0; g < ORDER; g++) begin : g_coef
    localparam logic signed [31:0] HW = coef_at(COEF_VEC_MAX'(COEF), ORDER, COEF_WIDTH, g);
    assign h[g] = HW[COEF_WIDTH-1:0];
  end

  // Stage 1: tap shift register
  logic signed [DATA_WIDTH-1:0] tap_p1_d [ORDER];
  logic signed [DATA_WIDTH-1:0] tap_p1_q [ORDER];
  logic                         vld_p1_d, vld_p1_q;

  always_comb begin
    tap_p1_d = tap_p1_q;
    vld_p1_d = d_vld;
    if (d_vld) begin
      tap_p1_d[0] = d;
      for (int k = 1; k < ORDER; k++) tap_p1_d[k] = tap_p1_q[k-1];
    end
  end

  // Stage 2: multiply-accumulate, floor shift, saturate
  logic signed [ACC_W-1:0]      acc_p1;
  logic signed [ACC_W-1:0]      shr_p1;
  logic signed [63:0]           sat_p1;
  logic signed [DATA_WIDTH-1:0] data_p2_d, data_p2_q;
  logic                         vld_p2_d, vld_p2_q;

  always_comb begin
    acc_p1 = '0;
    for (int k = 0; k < ORDER; k++) begin
      acc_p1 = acc_p1 + ACC_W'(tap_p1_q[k]) * ACC_W'(h[k]);
    end
    shr_p1    = acc_p1 >>> (COEF_WIDTH - 1);
    sat_p1    = sat_to(64'(shr_p1), DATA_WIDTH);
    data_p2_d = vld_p1_q ? sat_p1[DATA_WIDTH-1:0] : data_p2_q;
    vld_p2_d  = vld_p1_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < ORDER; k++) tap_p1_q[k] <= '0;
      vld_p1_q  <= 1'b0;
      data_p2_q <= '0;
      vld_p2_q  <= 1'b0;
    end else begin
      tap_p1_q  <= tap_p1_d;
      vld_p1_q  <= vld_p1_d;
      data_p2_q <= data_p2_d;
      vld_p2_q  <= vld_p2_d;
    end
  end

  assign data_o = data_p2_q;
  assign vld_o  = vld_p2_q;

endmodule

// File: tb/tb_fir_mod_delay.sv
// Scoreboard bench for fir_mod_delay: three instances (default, all-0x7F and
// mixed-sign coefficients) share one stimulus stream and one expected queue.
`timescale 1ns/1ps
module tb_fir_mod_delay;

  localparam int ORDER = 61;
  localparam int DW    = 8;
  localparam int CW    = 8;
  localparam int JW    = 9;

  function automatic int hc_mix(input int k);
    return ((k * 13) % 64) - 32;
  endfunction

  function automatic logic [ORDER*CW-1:0] mk_coef_mix();
    logic [ORDER*CW-1:0] v;
    v = '0;
    for (int k = 0; k < ORDER; k++) v[(ORDER-1-k)*CW +: CW] = CW'(hc_mix(k));
    return v;
  endfunction

  localparam logic [ORDER*CW-1:0] COEF_SAT = {ORDER{8'h7F}};
  localparam logic [ORDER*CW-1:0] COEF_MIX = mk_coef_mix();

  logic                 clk = 1'b0;
  logic                 rst;
  logic [JW-1:0]        jmp;
  logic signed [DW-1:0] data_i;
  logic                 vld_i;
  logic [DW-1:0]        do0, do1, do2;
  logic                 vo0, vo1, vo2;

  always #5 clk = ~clk;

  fir_mod_delay u_def (
    .clk(clk), .rst(rst), .jmp(jmp), .data_i(data_i), .vld_i(vld_i),
    .data_o(do0), .vld_o(vo0)
  );
  fir_mod_delay #(.COEF(COEF_SAT)) u_sat (
    .clk(clk), .rst(rst), .jmp(jmp), .data_i(data_i), .vld_i(vld_i),
    .data_o(do1), .vld_o(vo1)
  );
  fir_mod_delay #(.COEF(COEF_MIX)) u_mix (
    .clk(clk), .rst(rst), .jmp(jmp), .data_i(data_i), .vld_i(vld_i),
    .data_o(do2), .vld_o(vo2)
  );

  typedef struct packed {
    logic [2:0][7:0] y;
    int              due;
  } exp_t;

  exp_t q[$];
  int   hist[$];
  int   n_acc;
  int   taps[ORDER];
  int   cyc = 0;
  logic rst_prev = 1'b0;
  int   checks = 0;
  int   passes = 0;
  logic [2:0][7:0] last;
  logic [2:0][7:0] dv;
  logic [2:0]      vo;
  exp_t            mon_e;

  function automatic int coef(input int w, input int k);
    if (w == 0) return 2;
    if (w == 1) return 127;
    return hc_mix(k);
  endfunction

  function automatic logic [7:0] sat8(input longint v);
    if (v > 127)  return 8'h7F;
    if (v < -128) return 8'h80;
    return 8'(v);
  endfunction

  task automatic chk(input logic ok, input string name, input int act, input int exp_v);
    checks++;
    if (ok === 1'b1) passes++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp_v, cyc);
  endtask

  task automatic model_reset();
    hist.delete();
    n_acc = 0;
    for (int k = 0; k < ORDER; k++) taps[k] = 0;
  endtask

  // Delayed sample = value written jmp samples ago (or zero if none yet),
  // then a plain dot product with the coefficients and floor division by 128.
  task automatic model_push(input int x, input int j);
    int     d;
    longint acc;
    exp_t   e;
    if (j == 0)         d = x;
    else if (j > n_acc) d = 0;
    else                d = hist[hist.size() - j];
    hist.push_back(x);
    if (hist.size() > 1024) void'(hist.pop_front());
    n_acc++;
    for (int k = ORDER - 1; k > 0; k--) taps[k] = taps[k-1];
    taps[0] = d;
    for (int w = 0; w < 3; w++) begin
      acc = 0;
      for (int k = 0; k < ORDER; k++) acc += longint'(taps[k] * coef(w, k));
      e.y[w] = sat8(acc >>> 7);
    end
    e.due = cyc + 2;
    q.push_back(e);
  endtask

  task automatic drive(input logic v, input int x, input int j, input logic r);
    logic signed [7:0] xs;
    xs     = 8'(x);
    rst    = r;
    vld_i  = v;
    data_i = xs;
    jmp    = JW'(j);
    if (r) begin
      while (q.size() > 0 && q[$].due > cyc) void'(q.pop_back());
      model_reset();
    end else if (v) begin
      model_push(int'(xs), j);
    end
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_prev <= rst;
  end

  always @(negedge clk) begin
    if (cyc > 0) begin
      vo = {vo2, vo1, vo0};
      dv = {do2, do1, do0};
      if (rst_prev) begin
        for (int w = 0; w < 3; w++) begin
          chk(vo[w] == 1'b0, $sformatf("reset vld_o[%0d]", w), int'(vo[w]), 0);
          chk(dv[w] == 8'h00, $sformatf("reset data_o[%0d]", w), int'($signed(dv[w])), 0);
        end
        last = '0;
      end else if (q.size() > 0 && q[0].due == cyc) begin
        mon_e = q.pop_front();
        for (int w = 0; w < 3; w++) begin
          chk(vo[w] == 1'b1, $sformatf("vld_o latency[%0d]", w), int'(vo[w]), 1);
          chk(dv[w] == mon_e.y[w], $sformatf("data_o[%0d]", w),
              int'($signed(dv[w])), int'($signed(mon_e.y[w])));
          last[w] = mon_e.y[w];
        end
      end else begin
        for (int w = 0; w < 3; w++) begin
          chk(vo[w] == 1'b0, $sformatf("spurious vld_o[%0d]", w), int'(vo[w]), 0);
          chk(dv[w] == last[w], $sformatf("hold data_o[%0d]", w),
              int'($signed(dv[w])), int'($signed(last[w])));
        end
      end
    end
  end

  initial begin
    rst = 1'b1; vld_i = 1'b0; data_i = '0; jmp = '0;
    repeat (3) drive(1'b0, 0, 0, 1'b1);

    // impulse, jmp=0
    drive(1'b1, 64, 0, 1'b0);
    repeat (70) drive(1'b1, 0, 0, 1'b0);

    // positive and negative full-scale steps
    repeat (80) drive(1'b1, 127, 0, 1'b0);
    repeat (3) drive(1'b0, 0, 0, 1'b0);
    chk(last[0] == 8'h79, "step settle default", int'(last[0]), 8'h79);
    chk(last[1] == 8'h7F, "step saturate high", int'(last[1]), 8'h7F);
    repeat (80) drive(1'b1, -128, 0, 1'b0);
    repeat (3) drive(1'b0, 0, 0, 1'b0);
    chk(last[0] == 8'h86, "neg step default", int'(last[0]), 8'h86);
    chk(last[1] == 8'h80, "step saturate low", int'(last[1]), 8'h80);

    // impulse through a 10-sample delay right after reset
    repeat (2) drive(1'b0, 0, 0, 1'b1);
    drive(1'b1, 64, 10, 1'b0);
    repeat (80) drive(1'b1, 0, 10, 1'b0);

    // alternating valid
    for (int i = 0; i < 40; i++)
      drive(1'(i % 2 == 0), int'($urandom_range(0, 255)) - 128, 3, 1'b0);

    // ramp with stepping jmp and a mid-run reset (vld_i held high through it)
    for (int i = 0; i < 5000; i++) begin
      if (i == 2500 || i == 2501) drive(1'b1, i, 0, 1'b1);
      else drive(1'b1, i & 255, 10 + (i / 1000) * 10, 1'b0);
    end

    // random data, random gaps, random jmp including the deepest offsets
    for (int i = 0; i < 3000; i++) begin
      int j;
      if ($urandom_range(0, 3) == 0) j = 511 - int'($urandom_range(0, 3));
      else                           j = int'($urandom_range(0, 511));
      if (i == 1500) drive(1'b1, 0, j, 1'b1);
      else drive(1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 255)) - 128, j, 1'b0);
    end

    repeat (5) drive(1'b0, 0, 0, 1'b0);
    chk(q.size() == 0, "scoreboard drained", q.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
